// File: rtl/lv_reg_bank_pkg.sv
// Shared types and helpers for the lv register bank: FSM states, address regions
// and the decode that maps an address onto a region.
package lv_reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RGN_RO   = 2'd0,
        RGN_RW   = 2'd1,
        RGN_RWC  = 2'd2,
        RGN_NONE = 2'd3
    } region_t;

    localparam int unsigned RO_BASE = 0;

    // Regions are packed back to back: RO, then RW, then RWC.
    function automatic region_t region_decode(input int unsigned addr,
                                              input int unsigned num_ro,
                                              input int unsigned num_rw,
                                              input int unsigned num_rwc);
        if (addr < RO_BASE + num_ro)
            return RGN_RO;
        else if (addr < RO_BASE + num_ro + num_rw)
            return RGN_RW;
        else if (addr < RO_BASE + num_ro + num_rw + num_rwc)
            return RGN_RWC;
        else
            return RGN_NONE;
    endfunction

endpackage

// File: rtl/lv_reg_bank_if.sv
// SPI-side register access bus: single-cycle requests in, one-cycle acks out.
interface lv_reg_bank_if #(
    parameter int REG_AW = 7,
    parameter int REG_DW = 8
);
    logic              i_spi_reg_ren;
    logic              i_spi_reg_wen;
    logic [REG_AW-1:0] i_spi_reg_addr;
    logic [REG_DW-1:0] i_spi_reg_wdata;
    logic              o_reg_spi_rack;
    logic              o_reg_spi_wack;
    logic              o_reg_spi_rstatus;
    logic              o_reg_spi_wstatus;
    logic [REG_DW-1:0] o_reg_spi_rdata;
    logic              o_busy;

    modport master (
        output i_spi_reg_ren, i_spi_reg_wen, i_spi_reg_addr, i_spi_reg_wdata,
        input  o_reg_spi_rack, o_reg_spi_wack, o_reg_spi_rstatus, o_reg_spi_wstatus,
        input  o_reg_spi_rdata, o_busy
    );

    modport slave (
        input  i_spi_reg_ren, i_spi_reg_wen, i_spi_reg_addr, i_spi_reg_wdata,
        output o_reg_spi_rack, o_reg_spi_wack, o_reg_spi_rstatus, o_reg_spi_wstatus,
        output o_reg_spi_rdata, o_busy
    );
endinterface

// File: rtl/lv_rwc_bit_reg.sv
// Sticky status word: set pulses OR-accumulate every cycle, a read strobe clears
// the word, and a set arriving with the clear survives it.
module lv_rwc_bit_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_set,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            q_reg <= '0;
        else
            q_reg <= (q_reg & ~{WIDTH{i_clr}}) | i_set;
    end

    assign o_q = q_reg;
endmodule

// File: rtl/lv_reg_bank.sv
// Register bank with RO status, RW config and read-clear sticky words behind a
// three-state IDLE/ACCESS/RESP access FSM.
module lv_reg_bank
    import lv_reg_bank_pkg::*;
#(
    parameter int                          REG_AW         = 7,
    parameter int                          REG_DW         = 8,
    parameter int                          NUM_RO         = 4,
    parameter int                          NUM_RW         = 8,
    parameter int                          NUM_RWC        = 2,
    parameter logic [NUM_RW*REG_DW-1:0]    RW_DEFAULT     = '0,
    parameter logic [(1<<REG_AW)-1:0]      TEST_ONLY_MASK = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    lv_reg_bank_if.slave                 spi,
    input  logic [NUM_RO*REG_DW-1:0]     i_ro_data,
    input  logic [NUM_RWC*REG_DW-1:0]    i_rwc_set,
    output logic [NUM_RW*REG_DW-1:0]     o_rw_data,
    output logic [NUM_RWC*REG_DW-1:0]    o_rwc_data,
    input  logic                         i_test_mode_status,
    input  logic                         i_cfg_mode_status
);
    state_t            state_reg;
    logic [REG_AW-1:0] addr_reg;
    logic [REG_DW-1:0] wdata_reg;
    logic              rd_reg;
    logic              conflict_reg;
    logic              rack_reg, wack_reg, rstatus_reg, wstatus_reg;
    logic [REG_DW-1:0] rdata_reg;

    region_t           region;
    logic              reject;
    logic              resolve;
    logic [REG_DW-1:0] rdata_next;
    logic [NUM_RW-1:0] rw_wr;
    logic [NUM_RWC-1:0] rwc_clr;

    assign region  = region_decode(32'(addr_reg), NUM_RO, NUM_RW, NUM_RWC);
    assign resolve = (state_reg == ST_ACCESS);

    // Mode inputs are used live here, so they count as sampled at the resolving edge.
    always_comb begin
        reject = 1'b0;
        if (conflict_reg || region == RGN_NONE)
            reject = 1'b1;
        if (TEST_ONLY_MASK[addr_reg] && !i_test_mode_status)
            reject = 1'b1;
        if (!rd_reg && (region == RGN_RO || region == RGN_RWC))
            reject = 1'b1;
        if (!rd_reg && region == RGN_RW && !i_test_mode_status && !i_cfg_mode_status)
            reject = 1'b1;
    end

    always_comb begin
        rdata_next = '0;
        rw_wr      = '0;
        rwc_clr    = '0;
        for (int k = 0; k < NUM_RO; k++)
            if (addr_reg == REG_AW'(RO_BASE + k))
                rdata_next = i_ro_data[k*REG_DW +: REG_DW];
        for (int k = 0; k < NUM_RW; k++)
            if (addr_reg == REG_AW'(NUM_RO + k)) begin
                rdata_next = o_rw_data[k*REG_DW +: REG_DW];
                rw_wr[k]   = resolve && !rd_reg && !reject;
            end
        for (int k = 0; k < NUM_RWC; k++)
            if (addr_reg == REG_AW'(NUM_RO + NUM_RW + k)) begin
                rdata_next = o_rwc_data[k*REG_DW +: REG_DW];
                rwc_clr[k] = resolve && rd_reg && !reject;
            end
        if (reject)
            rdata_next = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rd_reg       <= 1'b0;
            conflict_reg <= 1'b0;
            rack_reg     <= 1'b0;
            wack_reg     <= 1'b0;
            rstatus_reg  <= 1'b0;
            wstatus_reg  <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (spi.i_spi_reg_ren || spi.i_spi_reg_wen) begin
                        state_reg    <= ST_ACCESS;
                        addr_reg     <= spi.i_spi_reg_addr;
                        wdata_reg    <= spi.i_spi_reg_wdata;
                        rd_reg       <= spi.i_spi_reg_ren;
                        conflict_reg <= spi.i_spi_reg_ren && spi.i_spi_reg_wen;
                    end
                end
                ST_ACCESS: begin
                    state_reg   <= ST_RESP;
                    rack_reg    <= rd_reg;
                    wack_reg    <= !rd_reg;
                    rstatus_reg <= rd_reg && reject;
                    wstatus_reg <= !rd_reg && reject;
                    rdata_reg   <= rd_reg ? rdata_next : '0;
                end
                ST_RESP: begin
                    state_reg   <= ST_IDLE;
                    rack_reg    <= 1'b0;
                    wack_reg    <= 1'b0;
                    rstatus_reg <= 1'b0;
                    wstatus_reg <= 1'b0;
                    rdata_reg   <= '0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RW; gi++) begin : g_rw
            logic [REG_DW-1:0] q_reg;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    q_reg <= RW_DEFAULT[gi*REG_DW +: REG_DW];
                else if (rw_wr[gi])
                    q_reg <= wdata_reg;
            end
            assign o_rw_data[gi*REG_DW +: REG_DW] = q_reg;
        end

        for (gi = 0; gi < NUM_RWC; gi++) begin : g_rwc
            lv_rwc_bit_reg #(.WIDTH(REG_DW)) u_rwc (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_set   (i_rwc_set[gi*REG_DW +: REG_DW]),
                .i_clr   (rwc_clr[gi]),
                .o_q     (o_rwc_data[gi*REG_DW +: REG_DW])
            );
        end
    endgenerate

    assign spi.o_reg_spi_rack    = rack_reg;
    assign spi.o_reg_spi_wack    = wack_reg;
    assign spi.o_reg_spi_rstatus = rstatus_reg;
    assign spi.o_reg_spi_wstatus = wstatus_reg;
    assign spi.o_reg_spi_rdata   = rdata_reg;
    assign spi.o_busy            = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_lv_reg_bank.sv
// Scoreboard bench for lv_reg_bank: each request pushes its expected ack, and a
// monitor on the falling edge pops and compares whenever an ack appears.
module tb_lv_reg_bank;
    localparam int AW = 7, DW = 8, NRO = 4, NRW = 8, NRWC = 2;
    localparam logic [NRW*DW-1:0]  RW_DEF = {8'hA5, 56'h0};
    localparam logic [(1<<AW)-1:0] TMASK  = 128'h80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    logic [NRO*DW-1:0]  ro_data;
    logic [NRWC*DW-1:0] rwc_set;
    logic [NRW*DW-1:0]  rw_data;
    logic [NRWC*DW-1:0] rwc_data;
    logic tm, cfg;

    lv_reg_bank_if #(.REG_AW(AW), .REG_DW(DW)) bus ();

    lv_reg_bank #(
        .REG_AW(AW), .REG_DW(DW), .NUM_RO(NRO), .NUM_RW(NRW), .NUM_RWC(NRWC),
        .RW_DEFAULT(RW_DEF), .TEST_ONLY_MASK(TMASK)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .spi                (bus),
        .i_ro_data          (ro_data),
        .i_rwc_set          (rwc_set),
        .o_rw_data          (rw_data),
        .o_rwc_data         (rwc_data),
        .i_test_mode_status (tm),
        .i_cfg_mode_status  (cfg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        is_rd;
        logic        status;
        logic [7:0]  data;
        int          cyc;
        string       tag;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (bus.o_reg_spi_rack || bus.o_reg_spi_wack) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_ack", {30'd0, bus.o_reg_spi_rack, bus.o_reg_spi_wack}, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val({mon_e.tag, "_ack_cycle"}, cyc, mon_e.cyc);
                check_val({mon_e.tag, "_ack_kind"}, {30'd0, bus.o_reg_spi_rack, bus.o_reg_spi_wack},
                          mon_e.is_rd ? 32'd2 : 32'd1);
                if (mon_e.is_rd) begin
                    check_val({mon_e.tag, "_rstatus"}, bus.o_reg_spi_rstatus, mon_e.status);
                    check_val({mon_e.tag, "_rdata"}, bus.o_reg_spi_rdata, mon_e.data);
                end else begin
                    check_val({mon_e.tag, "_wstatus"}, bus.o_reg_spi_wstatus, mon_e.status);
                end
                $display("[TB] %s done at cycle %0d", mon_e.tag, cyc);
            end
        end
    end

    task automatic access(input string tag, input logic ren, input logic wen,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic st, input logic [DW-1:0] d);
        @(negedge clk);
        bus.i_spi_reg_ren   = ren;
        bus.i_spi_reg_wen   = wen;
        bus.i_spi_reg_addr  = addr;
        bus.i_spi_reg_wdata = wd;
        sb_q.push_back('{is_rd: ren, status: st, data: d, cyc: cyc + 2, tag: tag});
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b0;
        bus.i_spi_reg_wen = 1'b0;
        check_val({tag, "_busy"}, bus.o_busy, 1);
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] addr, input logic st, input logic [DW-1:0] d);
        access(tag, 1'b1, 1'b0, addr, 8'h00, st, d);
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic st);
        access(tag, 1'b0, 1'b1, addr, wd, st, 8'h00);
    endtask

    task automatic pulse_set(input int k, input logic [DW-1:0] v);
        @(negedge clk);
        rwc_set[k*DW +: DW] = v;
        @(negedge clk);
        rwc_set = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [DW-1:0] ro_v;

    initial begin
        bus.i_spi_reg_ren = 1'b0; bus.i_spi_reg_wen = 1'b0;
        bus.i_spi_reg_addr = '0;  bus.i_spi_reg_wdata = '0;
        ro_data = {8'h44, 8'h33, 8'h22, 8'h11};
        rwc_set = '0; tm = 1'b0; cfg = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.o_busy, 0);
        check_val("rst_acks", {30'd0, bus.o_reg_spi_rack, bus.o_reg_spi_wack}, 0);
        check_val("rst_rdata", bus.o_reg_spi_rdata, 0);
        check_val("rst_rw_lo", rw_data[31:0], RW_DEF[31:0]);
        check_val("rst_rw_hi", rw_data[63:32], RW_DEF[63:32]);
        check_val("rst_rwc", rwc_data, 0);

        release_reset();
        rd("rd4_first", 7'd4, 1'b0, 8'h00);
        rd("rd11_default", 7'd11, 1'b0, 8'hA5);

        cfg = 1'b1;
        wr("wr5_cfg", 7'd5, 8'h5A, 1'b0);
        rd("rd5", 7'd5, 1'b0, 8'h5A);
        check_val("rw_slice1", rw_data[15:8], 8'h5A);

        cfg = 1'b0; tm = 1'b0;
        wr("wr6_nomode", 7'd6, 8'h33, 1'b1);
        rd("rd6_kept", 7'd6, 1'b0, 8'h00);
        cfg = 1'b1;
        wr("wr2_ro", 7'd2, 8'h12, 1'b1);
        wr("wr20_oor", 7'd20, 8'h12, 1'b1);
        wr("wr12_rwc", 7'd12, 8'hFF, 1'b1);
        rd("rd20_oor", 7'd20, 1'b1, 8'h00);
        rd("rd14_oor", 7'd14, 1'b1, 8'h00);

        for (int i = 0; i < NRO; i++) begin
            ro_v = 8'($urandom_range(0, 255));
            ro_data[i*DW +: DW] = ro_v;
            rd($sformatf("rd_ro%0d", i), 7'(i), 1'b0, ro_v);
        end

        pulse_set(0, 8'h81);
        check_val("rwc0_sticky", rwc_data[7:0], 8'h81);
        rd("rd12_first", 7'd12, 1'b0, 8'h81);
        rd("rd12_cleared", 7'd12, 1'b0, 8'h00);
        pulse_set(1, 8'h06);
        pulse_set(1, 8'h40);
        rd("rd13_accum", 7'd13, 1'b0, 8'h46);
        rd("rd13_cleared", 7'd13, 1'b0, 8'h00);

        // Set pulse lands on the same edge that resolves the clearing read.
        pulse_set(0, 8'h10);
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b1; bus.i_spi_reg_addr = 7'd12;
        sb_q.push_back('{is_rd: 1'b1, status: 1'b0, data: 8'h10, cyc: cyc + 2, tag: "rd12_coinc"});
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b0; rwc_set[7:0] = 8'h01;
        @(negedge clk);
        rwc_set = '0;
        rd("rd12_setwins", 7'd12, 1'b0, 8'h01);

        access("both_rw5", 1'b1, 1'b1, 7'd5, 8'h11, 1'b1, 8'h00);
        rd("rd5_after_both", 7'd5, 1'b0, 8'h5A);
        pulse_set(0, 8'h08);
        access("both_rwc12", 1'b1, 1'b1, 7'd12, 8'h00, 1'b1, 8'h00);
        rd("rd12_noclear", 7'd12, 1'b0, 8'h08);

        // Second request arrives while busy and must vanish without an ack.
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b1; bus.i_spi_reg_addr = 7'd4;
        sb_q.push_back('{is_rd: 1'b1, status: 1'b0, data: 8'h00, cyc: cyc + 2, tag: "drop_first"});
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b1; bus.i_spi_reg_wen = 1'b1; bus.i_spi_reg_addr = 7'd5;
        bus.i_spi_reg_wdata = 8'h99;
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b0; bus.i_spi_reg_wen = 1'b0;
        rd("rd5_after_drop", 7'd5, 1'b0, 8'h5A);

        cfg = 1'b0; tm = 1'b0;
        rd("rd7_testonly", 7'd7, 1'b1, 8'h00);
        tm = 1'b1;
        wr("wr7_test", 7'd7, 8'h77, 1'b0);
        rd("rd7_test", 7'd7, 1'b0, 8'h77);
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b1; bus.i_spi_reg_addr = 7'd7;
        sb_q.push_back('{is_rd: 1'b1, status: 1'b1, data: 8'h00, cyc: cyc + 2, tag: "rd7_tm_drop"});
        @(negedge clk);
        bus.i_spi_reg_ren = 1'b0; tm = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.i_spi_reg_wen = 1'b1; bus.i_spi_reg_addr = 7'd8; bus.i_spi_reg_wdata = 8'hC6;
        sb_q.push_back('{is_rd: 1'b0, status: 1'b0, data: 8'h00, cyc: cyc + 2, tag: "wr8_cfg_late"});
        @(negedge clk);
        bus.i_spi_reg_wen = 1'b0; cfg = 1'b1;
        @(negedge clk);
        rd("rd8_late", 7'd8, 1'b0, 8'hC6);

        // Abort a write in flight with reset.
        @(negedge clk);
        bus.i_spi_reg_wen = 1'b1; bus.i_spi_reg_addr = 7'd4; bus.i_spi_reg_wdata = 8'hFF;
        @(negedge clk);
        bus.i_spi_reg_wen = 1'b0;
        check_val("abort_busy", bus.o_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("abort_idle", bus.o_busy, 0);
        check_val("abort_rw_lo", rw_data[31:0], RW_DEF[31:0]);
        check_val("abort_rw_hi", rw_data[63:32], RW_DEF[63:32]);
        release_reset();
        rd("rd4_after_abort", 7'd4, 1'b0, 8'h00);
        rd("rd5_after_abort", 7'd5, 1'b0, 8'h00);
        rd("rd11_after_abort", 7'd11, 1'b0, 8'hA5);

        repeat (4) @(negedge clk);
        check_val("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lv_reg_bank.md
LV_REG_BANK -- requirements
Module: lv_reg_bank

Interface
REQ-001 Parameter REG_AW, 7, address width.
REQ-002 Parameter REG_DW, 8, data width.
REQ-003 Parameter NUM_RO, 4, read-only register count, range 1..32.
REQ-004 Parameter NUM_RW, 8, read-write register count, range 1..32.
REQ-005 Parameter NUM_RWC, 2, read-clear sticky register count, range 1..32.
REQ-006 Parameter RW_DEFAULT, all zero, NUM_RW*REG_DW reset image; RW register k is slice k.
REQ-007 Parameter TEST_ONLY_MASK, all zero, one bit per address: 1 = accessible only in test mode.
REQ-008 i_clk  in  1  clock.
REQ-009 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-010 i_spi_reg_ren / i_spi_reg_wen  in  1 each  single-cycle read / write request.
REQ-011 i_spi_reg_addr  in  REG_AW  access address.
REQ-012 i_spi_reg_wdata  in  REG_DW  write data.
REQ-013 o_reg_spi_rack / o_reg_spi_wack  out  1 each  one-cycle read / write completion pulse.
REQ-014 o_reg_spi_rstatus / o_reg_spi_wstatus  out  1 each  1 = access rejected; valid with its ack.
REQ-015 o_reg_spi_rdata  out  REG_DW  read data, valid with rack.
REQ-016 o_busy  out  1  access in progress; requests ignored.
REQ-017 i_ro_data  in  NUM_RO*REG_DW  live status words.
REQ-018 i_rwc_set  in  NUM_RWC*REG_DW  per-bit sticky set pulses.
REQ-019 o_rw_data / o_rwc_data  out  NUM_RW*REG_DW / NUM_RWC*REG_DW  register contents to inner logic.
REQ-020 i_test_mode_status / i_cfg_mode_status  in  1 each  mode qualifiers.

Function
REQ-021 Address map: RO at 0..NUM_RO-1, RW next NUM_RW addresses, RWC next NUM_RWC; higher addresses out of range.
REQ-022 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted request; ACCESS->RESP; RESP->IDLE unconditionally.
REQ-023 Request accepted only in IDLE; address and wdata captured at the accepting edge; requests in ACCESS/RESP dropped with no ack.
REQ-024 ren and wen asserted together: request accepted as a read, rstatus=1, rdata=0, no register effect.
REQ-025 o_busy = (state != IDLE), combinational from state.
REQ-026 Access resolved at the ACCESS->RESP edge; ack, status, rdata registered there and held during RESP only.
REQ-027 Latency: request in cycle 0 -> ack high exactly in cycle 2, low in cycle 3; next request accepted in cycle 3.
REQ-028 Rejection conditions: out of range; TEST_ONLY_MASK bit set and test mode low; write to RO or RWC address; write to RW with both mode inputs low.
REQ-029 Rejected access: status=1, rdata=0, no register change, no RWC clear.
REQ-030 Accepted RW write: register updated at the ACCESS->RESP edge; o_rw_data reflects it from cycle 2.
REQ-031 Read of RO returns i_ro_data sampled at the ACCESS->RESP edge.
REQ-032 Accepted RWC read returns the current value and clears it at the same edge.
REQ-033 RWC set pulse coincident with clear: set wins for that bit; other bits clear.
REQ-034 RWC bits set from i_rwc_set every cycle in every state; OR-accumulate until cleared.
REQ-035 Mode inputs sampled at the ACCESS->RESP edge; changes between request and resolution take effect.

Reset
REQ-036 Reset forces state IDLE, all acks/status/rdata 0, o_busy 0, RW registers to RW_DEFAULT, RWC registers to 0, captured address/wdata to 0.
REQ-037 Reset mid-access aborts it: no ack after release, no register change.
REQ-038 First request accepted on the first clock edge after reset release.

Structure
REQ-039 FSM state enum, address-region constants, and region-decode function in the shared lv package.
REQ-040 One sub-module: lv_rwc_bit_reg, a parametrised sticky set/read-clear register word.

Verification (defaults: RO 0-3, RW 4-11, RWC 12-13)
REQ-041 Reset release, read addr 4 -> rack cycle 2, rstatus 0, rdata 0x00.
REQ-042 cfg mode=1, write 0x5A to addr 5, read addr 5 -> wack cycle 2 wstatus 0; rdata 0x5A; o_rw_data slice 1 = 0x5A.
REQ-043 Both modes 0, write 0x33 to addr 6 -> wstatus 1, register stays 0x00; write addr 2 or addr 20 -> wstatus 1.
REQ-044 i_rwc_set slice 0 = 0x81 one cycle, read addr 12 twice -> 0x81 then 0x00; set 0x01 coincident with resolution edge -> next read 0x01.
REQ-045 ren in cycle 0, ren and wen in cycle 1 -> single rack in cycle 2, second request dropped; simultaneous ren+wen in IDLE -> rstatus 1.
REQ-046 i_rst_n low during ACCESS of write 0xFF to addr 4 -> no wack, addr 4 reads RW_DEFAULT slice 0 after release.
